hilo_div_ctrl: RTL and testbench

- Sits between the EX stage and IterDivider; owns the architectural HI/LO registers.
- Accepts DIV, DIVU, MTHI, MTLO, MFHI and MFLO from EX.
- Performs signed pre-conditioning (absolute values) and issues one unsigned request to IterDivider.
- Applies the sign fix-up to the returned quotient and remainder, writes LO/HI, and stalls the pipeline while a divide is outstanding.

---
 rtl/hilo_div_ctrl.sv | 141 ++++++++++++++
 tb/tb_hilo_div_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_ctrl.sv
// HI/LO register owner sitting between EX and the iterative divider.
// Decodes DIV/DIVU/MTHI/MTLO/MFHI/MFLO, conditions signed operands into
// magnitudes for the unsigned divider, restores signs on the result, and
// stalls the pipeline while a divide is outstanding.
module hilo_div_ctrl #(
  parameter logic [31:0] DIV0_LO = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] mf_data,
  output logic        pipe_stall,
  output logic        busy,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_in_valid,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_out_valid
);

  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4;
  localparam logic [2:0] OP_MFHI = 3'd5;
  localparam logic [2:0] OP_MFLO = 3'd6;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t      state_reg, state_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic [31:0] dividend_reg, dividend_next;
  logic [31:0] divisor_reg, divisor_next;
  logic        q_neg_reg, q_neg_next;
  logic        r_neg_reg, r_neg_next;

  logic        hilo_op;
  logic        is_signed;
  logic [31:0] rs_abs;
  logic [31:0] rt_abs;

  // Operand magnitudes; 0x80000000 maps onto itself, which the unsigned
  // divider reads correctly as 2^31.
  assign rs_abs    = rs_data[31] ? (~rs_data + 32'd1) : rs_data;
  assign rt_abs    = rt_data[31] ? (~rt_data + 32'd1) : rt_data;
  assign is_signed = (op == OP_DIV);
  assign hilo_op   = (op != 3'd0) && (op != 3'd7);

  assign hi_o         = hi_reg;
  assign lo_o         = lo_reg;
  assign div_dividend = dividend_reg;
  assign div_divisor  = divisor_reg;

  // State and datapath registers; reset aborts any divide in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      hi_reg       <= 32'd0;
      lo_reg       <= 32'd0;
      dividend_reg <= 32'd0;
      divisor_reg  <= 32'd0;
      q_neg_reg    <= 1'b0;
      r_neg_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      dividend_reg <= dividend_next;
      divisor_reg  <= divisor_next;
      q_neg_reg    <= q_neg_next;
      r_neg_reg    <= r_neg_next;
    end
  end

  // Next-state, register updates and handshake outputs.
  always_comb begin
    state_next    = state_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    dividend_next = dividend_reg;
    divisor_next  = divisor_reg;
    q_neg_next    = q_neg_reg;
    r_neg_next    = r_neg_reg;
    busy          = 1'b0;
    div_in_valid  = 1'b0;
    mf_data       = 32'd0;
    pipe_stall    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (op_valid) begin
          case (op)
            OP_DIV, OP_DIVU: begin
              if (rt_data == 32'd0) begin
                // Divide-by-zero resolves locally; the divider is never asked.
                lo_next = DIV0_LO;
                hi_next = rs_data;
              end else begin
                state_next    = ISSUE;
                dividend_next = is_signed ? rs_abs : rs_data;
                divisor_next  = is_signed ? rt_abs : rt_data;
                q_neg_next    = is_signed & (rs_data[31] ^ rt_data[31]);
                r_neg_next    = is_signed & rs_data[31];
              end
            end
            OP_MTHI: hi_next = rs_data;
            OP_MTLO: lo_next = rs_data;
            OP_MFHI: mf_data = hi_reg;
            OP_MFLO: mf_data = lo_reg;
            default: ;
          endcase
        end
      end
      ISSUE: begin
        busy         = 1'b1;
        div_in_valid = 1'b1;
        state_next   = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (div_out_valid) begin
          // Remainder takes the dividend's sign, quotient the XOR of signs.
          lo_next    = q_neg_reg ? (~div_quotient + 32'd1) : div_quotient;
          hi_next    = r_neg_reg ? (~div_remainder + 32'd1) : div_remainder;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    pipe_stall = op_valid & busy & hilo_op;
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl: a behavioural 32-iteration divider stand-in,
// directed scenarios, then randomized ops checked against an arithmetic
// model of HI/LO.
module tb_hilo_div_ctrl;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4;
  localparam logic [2:0] OP_MFHI = 3'd5;
  localparam logic [2:0] OP_MFLO = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic [31:0] mf_data;
  logic        pipe_stall;
  logic        busy;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div_in_valid;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        div_out_valid;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  hilo_div_ctrl #(.DIV0_LO(32'hFFFFFFFF)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .mf_data(mf_data),
    .pipe_stall(pipe_stall), .busy(busy), .hi_o(hi_o), .lo_o(lo_o),
    .div_in_valid(div_in_valid), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .div_out_valid(div_out_valid)
  );

  always #5 clk = ~clk;

  // Divider stand-in: captures on in_valid, answers 33 edges later so that
  // out_valid is high in cycle 34 when the accept happened in cycle 0.
  logic [31:0] m_dd = 32'd0;
  logic [31:0] m_dv = 32'd1;
  int          m_cnt = 0;
  logic        stray = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) m_cnt <= 0;
    else if (div_in_valid) begin
      m_cnt <= 33;
      m_dd  <= div_dividend;
      m_dv  <= div_divisor;
    end else if (m_cnt > 0) m_cnt <= m_cnt - 1;
  end

  assign div_out_valid = (m_cnt == 1) | stray;
  assign div_quotient  = (m_dv == 32'd0) ? 32'd0 : m_dd / m_dv;
  assign div_remainder = (m_dv == 32'd0) ? 32'd0 : m_dd % m_dv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    compared++;
    assert (obs === want) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Architectural result of a divide, from signed/unsigned arithmetic.
  task automatic ref_div(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic [31:0] dd, output logic [31:0] dv, output bit zero);
    longint sa, sb, sq, sr;
    zero = (b == 32'd0);
    sa = $signed(a);
    sb = $signed(b);
    if (zero) begin
      q = 32'hFFFFFFFF; r = a; dd = 32'd0; dv = 32'd0;
    end else if (o == OP_DIV) begin
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[31:0];
      r  = sr[31:0];
      sa = (sa < 0) ? -sa : sa;
      sb = (sb < 0) ? -sb : sb;
      dd = sa[31:0];
      dv = sb[31:0];
    end else begin
      q = a / b; r = a % b; dd = a; dv = b;
    end
  endtask

  // Full divide transaction from accept (cycle 0) to visible result (cycle 35).
  task automatic do_div(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r, dd, dv;
    bit zero;
    int errs;
    ref_div(o, a, b, q, r, dd, dv, zero);
    op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
    smp();
    chk("c0_stall", pipe_stall, 1'b0);
    chk("c0_busy", busy, 1'b0);
    tick();
    op_valid = 1'b0; op = OP_NOP; rs_data = $urandom; rt_data = $urandom;
    smp();
    if (zero) begin
      exp_lo = q; exp_hi = r;
      chk("dz_in_valid", div_in_valid, 1'b0);
      chk("dz_busy", busy, 1'b0);
      chk("dz_lo", lo_o, exp_lo);
      chk("dz_hi", hi_o, exp_hi);
      $display("div op=%0d rs=%h rt=%h -> lo=%h hi=%h (div0)", o, a, b, lo_o, hi_o);
      return;
    end
    chk("c1_in_valid", div_in_valid, 1'b1);
    chk("c1_dividend", div_dividend, dd);
    chk("c1_divisor", div_divisor, dv);
    chk("c1_busy", busy, 1'b1);
    errs = 0;
    for (int c = 2; c <= 34; c++) begin
      tick();
      smp();
      if (div_in_valid !== 1'b0 || busy !== 1'b1 || div_dividend !== dd ||
          div_divisor !== dv || hi_o !== exp_hi || lo_o !== exp_lo) errs++;
    end
    chk("wait_phase_errs", errs, 0);
    tick();
    smp();
    exp_lo = q; exp_hi = r;
    chk("c35_busy", busy, 1'b0);
    chk("c35_lo", lo_o, exp_lo);
    chk("c35_hi", hi_o, exp_hi);
    $display("div op=%0d rs=%h rt=%h -> lo=%h hi=%h", o, a, b, lo_o, hi_o);
  endtask

  task automatic do_idle(input logic [2:0] o, input logic [31:0] a);
    logic [31:0] want_mf;
    op_valid = 1'b1; op = o; rs_data = a; rt_data = $urandom;
    want_mf = (o == OP_MFHI) ? exp_hi : (o == OP_MFLO) ? exp_lo : 32'd0;
    smp();
    chk("idle_mf", mf_data, want_mf);
    chk("idle_stall", pipe_stall, 1'b0);
    if (o == OP_MTHI) exp_hi = a;
    if (o == OP_MTLO) exp_lo = a;
    tick();
    op_valid = 1'b0; op = OP_NOP;
    smp();
    chk("idle_hi", hi_o, exp_hi);
    chk("idle_lo", lo_o, exp_lo);
    $display("idle op=%0d rs=%h -> mf=%h hi=%h lo=%h", o, a, want_mf, hi_o, lo_o);
  endtask

  // DIVU 100/7 with a second HI/LO op held from cycle 'start' onwards.
  task automatic div_contend(input logic [2:0] o2, input int start, input logic [31:0] a2);
    int errs;
    logic [31:0] want_mf;
    op_valid = 1'b1; op = OP_DIVU; rs_data = 32'd100; rt_data = 32'd7;
    smp();
    errs = 0;
    for (int c = 1; c <= 35; c++) begin
      tick();
      op_valid = (c >= start); op = (c >= start) ? o2 : OP_NOP; rs_data = a2;
      smp();
      if (c <= 34) begin
        if (pipe_stall !== (c >= start) || mf_data !== 32'd0 || busy !== 1'b1) errs++;
      end
    end
    chk("contend_stall_errs", errs, 0);
    want_mf = (o2 == OP_MFHI) ? 32'd2 : 32'd0;
    chk("contend_c35_stall", pipe_stall, 1'b0);
    chk("contend_c35_mf", mf_data, want_mf);
    chk("contend_c35_lo", lo_o, 32'd14);
    exp_lo = (o2 == OP_MTLO) ? a2 : 32'd14;
    exp_hi = 32'd2;
    tick();
    op_valid = 1'b0; op = OP_NOP;
    smp();
    chk("contend_c36_lo", lo_o, exp_lo);
    chk("contend_c36_hi", hi_o, exp_hi);
    $display("contend op=%0d from c%0d -> mf@35=%h lo=%h hi=%h", o2, start, mf_data, lo_o, hi_o);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    int errs;
    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    smp();
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_stall", pipe_stall, 1'b0);
    chk("rst_in_valid", div_in_valid, 1'b0);
    chk("rst_dividend", div_dividend, 32'd0);
    chk("rst_divisor", div_divisor, 32'd0);
    chk("rst_mf", mf_data, 32'd0);
    $display("reset: hi=%h lo=%h busy=%b", hi_o, lo_o, busy);
    tick();
    rst_n = 1'b1;

    // Directed divides with hand-derived results
    do_div(OP_DIVU, 32'd100, 32'd7);
    chk("tp_divu_lo", lo_o, 32'd14);
    chk("tp_divu_hi", hi_o, 32'd2);
    tick();
    do_div(OP_DIV, 32'hFFFFFFF9, 32'd2);
    chk("tp_negdvd_lo", lo_o, 32'hFFFFFFFD);
    chk("tp_negdvd_hi", hi_o, 32'hFFFFFFFF);
    tick();
    do_div(OP_DIV, 32'd7, 32'hFFFFFFFE);
    chk("tp_negdvs_lo", lo_o, 32'hFFFFFFFD);
    chk("tp_negdvs_hi", hi_o, 32'd1);
    tick();
    do_div(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    chk("tp_ovf_lo", lo_o, 32'h80000000);
    chk("tp_ovf_hi", hi_o, 32'd0);
    tick();
    do_div(OP_DIVU, 32'h1234, 32'd0);
    chk("tp_dz_lo", lo_o, 32'hFFFFFFFF);
    chk("tp_dz_hi", hi_o, 32'h1234);
    tick();

    // Stall behaviour around completion
    div_contend(OP_MFHI, 5, 32'd0);
    tick();
    div_contend(OP_MTLO, 34, 32'h0000ABCD);
    tick();

    // Reset in the middle of a signed divide
    op_valid = 1'b1; op = OP_DIV; rs_data = 32'hFFFFFFF9; rt_data = 32'd2;
    for (int c = 1; c <= 10; c++) begin
      tick();
      op_valid = 1'b0; op = OP_NOP;
      if (c == 10) rst_n = 1'b0;
    end
    tick();
    rst_n = 1'b1;
    smp();
    exp_hi = 32'd0; exp_lo = 32'd0;
    chk("abort_hi", hi_o, 32'd0);
    chk("abort_lo", lo_o, 32'd0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_in_valid", div_in_valid, 1'b0);
    $display("abort: hi=%h lo=%h busy=%b", hi_o, lo_o, busy);
    tick();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    errs = 0;
    for (int c = 0; c < 40; c++) begin
      smp();
      if (hi_o !== 32'd0 || lo_o !== 32'd0 || busy !== 1'b0) errs++;
      tick();
    end
    chk("stray_ignored_errs", errs, 0);
    do_div(OP_DIVU, 32'd9, 32'd3);
    chk("post_abort_lo", lo_o, 32'd3);
    chk("post_abort_hi", hi_o, 32'd0);
    tick();

    // NOP / reserved leave everything alone
    do_idle(OP_NOP, 32'hDEADBEEF);
    tick();
    do_idle(3'd7, 32'hDEADBEEF);
    tick();

    // Randomized mix against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = $urandom_range(1, 20);
        3: b = -$urandom_range(1, 20);
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      case ($urandom_range(0, 9))
        0, 1, 2: do_div(OP_DIV, a, b);
        3, 4:    do_div(OP_DIVU, a, b);
        5:       do_idle(OP_MTHI, a);
        6:       do_idle(OP_MTLO, a);
        7:       do_idle(OP_MFHI, a);
        8:       do_idle(OP_MFLO, a);
        default: do_idle(3'($urandom_range(0, 1) * 7), a);
      endcase
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
